// File: rtl/i2c_line_conditioner_pkg.sv
// i2c_cond_pkg: shared constants and helpers for the I2C line conditioner.
//   SYNC_STAGES_DEF  default synchroniser depth on each raw pad input
//   FILT_CYCLES_DEF  default consecutive-stable count before a filtered line moves
//   STUCK_CYCLES_DEF default low-without-edge time before the bus is flagged hung
//   clog2()          ceil(log2(n)); counter widths are clog2(max_count + 1)
package i2c_cond_pkg;

  localparam int unsigned SYNC_STAGES_DEF  = 2;
  localparam int unsigned FILT_CYCLES_DEF  = 4;
  localparam int unsigned STUCK_CYCLES_DEF = 1250000;

  function automatic int unsigned clog2(input longint unsigned n);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/i2c_line_conditioner_if.sv
// i2c_line_conditioner_if: pad, conduit and monitor signals of the line conditioner.
//   pad_*_in            raw asynchronous pad levels
//   master_*_oe         open-drain enables from the master conduit (1 = pull low)
//   slave_*_oe          open-drain enables from the slave conduit (1 = pull low)
//   pad_*_oe            merged registered pad drive (1 = drive 0)
//   sda_filt/scl_filt   synchronised, glitch-filtered line levels
//   start/stop_pulse    one-cycle bus condition strobes
//   bus_busy/stuck_low  bus state and hang flags
// Modport slave is the conditioner itself; modport master is the surrounding system.
interface i2c_line_conditioner_if;

  logic pad_sda_in;
  logic pad_scl_in;
  logic master_sda_oe;
  logic master_scl_oe;
  logic slave_sda_oe;
  logic slave_scl_oe;
  logic pad_sda_oe;
  logic pad_scl_oe;
  logic sda_filt;
  logic scl_filt;
  logic start_pulse;
  logic stop_pulse;
  logic bus_busy;
  logic stuck_low;

  modport slave (
    input  pad_sda_in, pad_scl_in,
    input  master_sda_oe, master_scl_oe, slave_sda_oe, slave_scl_oe,
    output pad_sda_oe, pad_scl_oe,
    output sda_filt, scl_filt,
    output start_pulse, stop_pulse, bus_busy, stuck_low
  );

  modport master (
    output pad_sda_in, pad_scl_in,
    output master_sda_oe, master_scl_oe, slave_sda_oe, slave_scl_oe,
    input  pad_sda_oe, pad_scl_oe,
    input  sda_filt, scl_filt,
    input  start_pulse, stop_pulse, bus_busy, stuck_low
  );

endinterface

// File: rtl/i2c_line_conditioner_glitch_filter.sv
// i2c_glitch_filter: synchroniser plus stable-count filter for one I2C line.
//   clk, rst    clock and synchronous active-high reset
//   pad_in      raw asynchronous pad level
//   filt        filtered level, moves only after FILT_CYCLES consecutive
//               synchronised samples disagree with it
//   filt_edge   high in the cycle before filt changes (filt flips on the next edge)
module i2c_glitch_filter
  import i2c_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned FILT_CYCLES = FILT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_in,
  output logic filt,
  output logic filt_edge
);

  localparam int unsigned      CNT_W    = clog2(FILT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sync_out;
  logic [CNT_W-1:0]       stable_cnt;

  // Stage p0: synchroniser chain, idle-high so reset never looks like a START
  always_ff @(posedge clk) begin
    if (rst) sync_p0 <= '1;
    else     sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pad_in};
  end

  assign sync_out = sync_p0[SYNC_STAGES-1];

  // The count holds the number of disagreeing samples already seen, so the
  // FILT_CYCLES-th one arrives while the count sits at FILT_CYCLES-1.
  assign filt_edge = (sync_out != filt) && (stable_cnt == CNT_LAST);

  // Stage p1: stable-count filter
  always_ff @(posedge clk) begin
    if (rst) begin
      filt       <= 1'b1;
      stable_cnt <= '0;
    end else if (sync_out == filt) begin
      stable_cnt <= '0;
    end else if (filt_edge) begin
      filt       <= sync_out;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_line_conditioner.sv
// i2c_line_conditioner: pin-side conditioning between the I2C pads and the
// master/slave conduits.
//   clk_clk      system clock
//   reset_reset  synchronous active-high reset
//   bus          i2c_line_conditioner_if.slave: pad levels in, conduit enables in,
//                merged pad drive, filtered levels, START/STOP strobes,
//                bus_busy and stuck_low out
// The block only monitors the bus; recovery from a hang is left to firmware.
module i2c_line_conditioner
  import i2c_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int unsigned FILT_CYCLES  = FILT_CYCLES_DEF,
  parameter int unsigned STUCK_CYCLES = STUCK_CYCLES_DEF
) (
  input logic                   clk_clk,
  input logic                   reset_reset,
  i2c_line_conditioner_if.slave bus
);

  localparam int unsigned        STUCK_W   = clog2(STUCK_CYCLES + 1);
  localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CYCLES);

  logic               sda_filt_p0;
  logic               scl_filt_p0;
  logic               sda_edge;
  logic               scl_edge;
  logic               sda_d_p1;
  logic               scl_d_p1;
  logic               start_det;
  logic               stop_det;
  logic               both_high;
  logic               stuck_rise;
  logic [STUCK_W-1:0] stuck_cnt;
  logic [STUCK_W-1:0] stuck_cnt_nxt;
  logic               start_p1;
  logic               stop_p1;
  logic               busy;
  logic               stuck;

  i2c_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_CYCLES (FILT_CYCLES)
  ) u_sda_filter (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .pad_in    (bus.pad_sda_in),
    .filt      (sda_filt_p0),
    .filt_edge (sda_edge)
  );

  i2c_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_CYCLES (FILT_CYCLES)
  ) u_scl_filter (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .pad_in    (bus.pad_scl_in),
    .filt      (scl_filt_p0),
    .filt_edge (scl_edge)
  );

  // Stage p0: merged open-drain drive; nothing else may pull the pads
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      bus.pad_sda_oe <= 1'b0;
      bus.pad_scl_oe <= 1'b0;
    end else begin
      bus.pad_sda_oe <= bus.master_sda_oe | bus.slave_sda_oe;
      bus.pad_scl_oe <= bus.master_scl_oe | bus.slave_scl_oe;
    end
  end

  // SCL must be high and unchanged across the SDA transition, so a
  // simultaneous SDA/SCL change can never qualify as START or STOP.
  assign start_det = sda_d_p1 & ~sda_filt_p0 & scl_d_p1 & scl_filt_p0;
  assign stop_det  = ~sda_d_p1 & sda_filt_p0 & scl_d_p1 & scl_filt_p0;
  assign both_high = sda_filt_p0 & scl_filt_p0;

  // Filter edge strobes clear the count on the same edge the line moves, so
  // the hang time is measured from the filtered transition itself.
  always_comb begin
    stuck_cnt_nxt = stuck_cnt;
    if (both_high || sda_edge || scl_edge) stuck_cnt_nxt = '0;
    else if (stuck_cnt != STUCK_MAX)       stuck_cnt_nxt = stuck_cnt + 1'b1;
  end

  assign stuck_rise = ~stuck & ~both_high & (stuck_cnt_nxt == STUCK_MAX);

  // Stage p1: event strobes, busy flag and stuck monitor
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sda_d_p1  <= 1'b1;
      scl_d_p1  <= 1'b1;
      start_p1  <= 1'b0;
      stop_p1   <= 1'b0;
      busy      <= 1'b0;
      stuck     <= 1'b0;
      stuck_cnt <= '0;
    end else begin
      sda_d_p1  <= sda_filt_p0;
      scl_d_p1  <= scl_filt_p0;
      start_p1  <= start_det;
      stop_p1   <= stop_det;
      stuck_cnt <= stuck_cnt_nxt;
      if (stop_det || stuck_rise) busy <= 1'b0;
      else if (start_det)         busy <= 1'b1;
      if (both_high)       stuck <= 1'b0;
      else if (stuck_rise) stuck <= 1'b1;
    end
  end

  assign bus.sda_filt    = sda_filt_p0;
  assign bus.scl_filt    = scl_filt_p0;
  assign bus.start_pulse = start_p1;
  assign bus.stop_pulse  = stop_p1;
  assign bus.bus_busy    = busy;
  assign bus.stuck_low   = stuck;

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// Testbench for i2c_line_conditioner: directed scenarios with literal
// expectations plus randomised pad/enable traffic, all checked each cycle
// against a window/timestamp reference model of the conditioner.
module tb_i2c_line_conditioner;

  localparam int SYNC  = 2;
  localparam int FILT  = 4;
  localparam int STUCK = 100;

  logic clk = 1'b0;
  logic reset_reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic cmp_en = 1'b0;

  i2c_line_conditioner_if bus ();

  i2c_line_conditioner #(
    .SYNC_STAGES  (SYNC),
    .FILT_CYCLES  (FILT),
    .STUCK_CYCLES (STUCK)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (reset_reset),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // q_*: pad samples still travelling through the synchroniser
  // w_*: the most recent FILT samples seen by the filter
  // A filtered line flips once its last FILT samples all disagree with it.
  logic q_sda[$], q_scl[$], w_sda[$], w_scl[$];
  logic m_sda_f, m_scl_f, m_sda_f1, m_scl_f1;
  logic m_start, m_stop, m_busy, m_stuck, m_pad_sda_oe, m_pad_scl_oe;
  int   cyc = 0;
  int   last_clear = 0;

  function automatic logic all_differ(input logic w[$], input logic f);
    if (w.size() != FILT) return 1'b0;
    foreach (w[i]) if (w[i] == f) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    logic in_s, in_c, ns, nc, both_hi, st, sp, nstuck;
    cyc++;
    if (reset_reset) begin
      q_sda.delete(); q_scl.delete(); w_sda.delete(); w_scl.delete();
      for (int i = 0; i < SYNC; i++) begin
        q_sda.push_back(1'b1);
        q_scl.push_back(1'b1);
      end
      m_sda_f = 1'b1; m_scl_f = 1'b1; m_sda_f1 = 1'b1; m_scl_f1 = 1'b1;
      m_start = 1'b0; m_stop = 1'b0; m_busy = 1'b0; m_stuck = 1'b0;
      m_pad_sda_oe = 1'b0; m_pad_scl_oe = 1'b0;
      last_clear = cyc;
    end else begin
      m_pad_sda_oe = bus.master_sda_oe | bus.slave_sda_oe;
      m_pad_scl_oe = bus.master_scl_oe | bus.slave_scl_oe;
      q_sda.push_back(bus.pad_sda_in); in_s = q_sda.pop_front();
      q_scl.push_back(bus.pad_scl_in); in_c = q_scl.pop_front();
      w_sda.push_back(in_s); if (w_sda.size() > FILT) void'(w_sda.pop_front());
      w_scl.push_back(in_c); if (w_scl.size() > FILT) void'(w_scl.pop_front());
      ns = all_differ(w_sda, m_sda_f) ? ~m_sda_f : m_sda_f;
      nc = all_differ(w_scl, m_scl_f) ? ~m_scl_f : m_scl_f;
      both_hi = m_sda_f & m_scl_f;
      if (both_hi || ns != m_sda_f || nc != m_scl_f) last_clear = cyc;
      nstuck = both_hi ? 1'b0 : (m_stuck || (cyc - last_clear >= STUCK));
      st = m_sda_f1 & ~m_sda_f & m_scl_f1 & m_scl_f;
      sp = ~m_sda_f1 & m_sda_f & m_scl_f1 & m_scl_f;
      if (sp || (nstuck && !m_stuck)) m_busy = 1'b0;
      else if (st)                    m_busy = 1'b1;
      m_start = st; m_stop = sp; m_stuck = nstuck;
      m_sda_f1 = m_sda_f; m_scl_f1 = m_scl_f;
      m_sda_f = ns; m_scl_f = nc;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Literal expectation applied to both the DUT and the model.
  task automatic lit(input string name, input logic act, input logic mdl, input logic exp);
    check({name, " (dut)"}, act, exp);
    check({name, " (model)"}, mdl, exp);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("pad_sda_oe",  bus.pad_sda_oe,  m_pad_sda_oe);
      check("pad_scl_oe",  bus.pad_scl_oe,  m_pad_scl_oe);
      check("sda_filt",    bus.sda_filt,    m_sda_f);
      check("scl_filt",    bus.scl_filt,    m_scl_f);
      check("start_pulse", bus.start_pulse, m_start);
      check("stop_pulse",  bus.stop_pulse,  m_stop);
      check("bus_busy",    bus.bus_busy,    m_busy);
      check("stuck_low",   bus.stuck_low,   m_stuck);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   sda_hold, scl_hold;
    logic long_mode;
    reset_reset = 1'b1;
    bus.pad_sda_in = 1'b1; bus.pad_scl_in = 1'b1;
    bus.master_sda_oe = 1'b0; bus.master_scl_oe = 1'b0;
    bus.slave_sda_oe = 1'b0; bus.slave_scl_oe = 1'b0;
    step(1);
    cmp_en = 1'b1;
    step(2);

    // Reset values after three reset cycles with idle pads
    lit("rst pad_sda_oe", bus.pad_sda_oe, m_pad_sda_oe, 1'b0);
    lit("rst pad_scl_oe", bus.pad_scl_oe, m_pad_scl_oe, 1'b0);
    lit("rst sda_filt", bus.sda_filt, m_sda_f, 1'b1);
    lit("rst scl_filt", bus.scl_filt, m_scl_f, 1'b1);
    lit("rst start", bus.start_pulse, m_start, 1'b0);
    lit("rst stop", bus.stop_pulse, m_stop, 1'b0);
    lit("rst busy", bus.bus_busy, m_busy, 1'b0);
    lit("rst stuck", bus.stuck_low, m_stuck, 1'b0);
    reset_reset = 1'b0;
    step(2);

    // Drive merge
    bus.master_scl_oe = 1'b1; step(1);
    lit("merge master", bus.pad_scl_oe, m_pad_scl_oe, 1'b1);
    bus.slave_scl_oe = 1'b1; step(1);
    bus.master_scl_oe = 1'b0; step(1);
    lit("merge slave only", bus.pad_scl_oe, m_pad_scl_oe, 1'b1);
    bus.slave_scl_oe = 1'b0; step(1);
    lit("merge released", bus.pad_scl_oe, m_pad_scl_oe, 1'b0);
    step(2);

    // Glitch rejection: 3-cycle low never reaches the filtered line
    bus.pad_sda_in = 1'b0; step(3);
    bus.pad_sda_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      lit("glitch3 sda_filt", bus.sda_filt, m_sda_f, 1'b1);
    end
    // 10-cycle low: falls 6 cycles after the pad edge, rises 6 after release
    bus.pad_sda_in = 1'b0; step(5);
    lit("low10 before fall", bus.sda_filt, m_sda_f, 1'b1);
    step(1);
    lit("low10 fall", bus.sda_filt, m_sda_f, 1'b0);
    step(4);
    bus.pad_sda_in = 1'b1; step(5);
    lit("low10 before rise", bus.sda_filt, m_sda_f, 1'b0);
    step(1);
    lit("low10 rise", bus.sda_filt, m_sda_f, 1'b1);
    step(6);

    // START / STOP
    bus.pad_sda_in = 1'b0; step(6);
    lit("start not yet", bus.start_pulse, m_start, 1'b0);
    step(1);
    lit("start pulse", bus.start_pulse, m_start, 1'b1);
    lit("start busy", bus.bus_busy, m_busy, 1'b1);
    step(1);
    lit("start pulse ends", bus.start_pulse, m_start, 1'b0);
    lit("busy held", bus.bus_busy, m_busy, 1'b1);
    bus.pad_sda_in = 1'b1; step(7);
    lit("stop pulse", bus.stop_pulse, m_stop, 1'b1);
    lit("stop busy", bus.bus_busy, m_busy, 1'b0);
    step(1);
    lit("stop pulse ends", bus.stop_pulse, m_stop, 1'b0);
    // SDA data toggles while SCL is low
    bus.pad_scl_in = 1'b0; step(8);
    bus.pad_sda_in = 1'b0; step(8);
    lit("data toggle start", bus.start_pulse, m_start, 1'b0);
    bus.pad_sda_in = 1'b1; step(8);
    lit("data toggle stop", bus.stop_pulse, m_stop, 1'b0);
    lit("data toggle busy", bus.bus_busy, m_busy, 1'b0);
    bus.pad_scl_in = 1'b1; step(8);

    // Repeated START, then simultaneous edges
    bus.pad_sda_in = 1'b0; step(8);
    bus.pad_scl_in = 1'b0; step(8);
    bus.pad_sda_in = 1'b1; step(8);
    bus.pad_scl_in = 1'b1; step(8);
    bus.pad_sda_in = 1'b0; step(7);
    lit("rstart pulse", bus.start_pulse, m_start, 1'b1);
    lit("rstart busy", bus.bus_busy, m_busy, 1'b1);
    step(1);
    bus.pad_sda_in = 1'b1; bus.pad_scl_in = 1'b0; step(7);
    lit("simul no stop", bus.stop_pulse, m_stop, 1'b0);
    lit("simul busy", bus.bus_busy, m_busy, 1'b1);
    step(1);
    bus.pad_sda_in = 1'b0; bus.pad_scl_in = 1'b1; step(7);
    lit("simul no start", bus.start_pulse, m_start, 1'b0);
    step(1);
    bus.pad_sda_in = 1'b1; step(8);
    lit("final stop busy", bus.bus_busy, m_busy, 1'b0);

    // Stuck: START, then hold SCL low
    bus.pad_sda_in = 1'b0; step(8);
    lit("pre-stuck busy", bus.bus_busy, m_busy, 1'b1);
    bus.pad_scl_in = 1'b0; step(105);
    lit("stuck not yet", bus.stuck_low, m_stuck, 1'b0);
    lit("busy before stuck", bus.bus_busy, m_busy, 1'b1);
    step(1);
    lit("stuck rises", bus.stuck_low, m_stuck, 1'b1);
    lit("stuck clears busy", bus.bus_busy, m_busy, 1'b0);
    bus.pad_scl_in = 1'b1; step(8);
    lit("stuck held sda low", bus.stuck_low, m_stuck, 1'b1);
    bus.pad_sda_in = 1'b1; step(6);
    lit("both high sda_filt", bus.sda_filt, m_sda_f, 1'b1);
    lit("stuck still set", bus.stuck_low, m_stuck, 1'b1);
    step(1);
    lit("stuck released", bus.stuck_low, m_stuck, 1'b0);
    step(4);

    // Reset mid-transfer
    bus.pad_sda_in = 1'b0; step(8);
    lit("mid busy", bus.bus_busy, m_busy, 1'b1);
    reset_reset = 1'b1; step(1);
    lit("mid rst busy", bus.bus_busy, m_busy, 1'b0);
    lit("mid rst sda_filt", bus.sda_filt, m_sda_f, 1'b1);
    bus.pad_sda_in = 1'b1; step(1);
    reset_reset = 1'b0; step(4);

    // Randomised traffic: alternating short-glitch and long-hold phases
    sda_hold = 0; scl_hold = 0; long_mode = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if (i % 1000 == 0) long_mode = ~long_mode;
      if (sda_hold == 0) begin
        bus.pad_sda_in = 1'($urandom_range(0, 1));
        sda_hold = long_mode ? int'($urandom_range(20, 180)) : int'($urandom_range(1, 9));
      end else sda_hold--;
      if (scl_hold == 0) begin
        bus.pad_scl_in = 1'($urandom_range(0, 1));
        scl_hold = long_mode ? int'($urandom_range(20, 180)) : int'($urandom_range(1, 9));
      end else scl_hold--;
      if ($urandom_range(0, 3) == 0) begin
        bus.master_sda_oe = 1'($urandom_range(0, 1));
        bus.master_scl_oe = 1'($urandom_range(0, 1));
        bus.slave_sda_oe  = 1'($urandom_range(0, 1));
        bus.slave_scl_oe  = 1'($urandom_range(0, 1));
      end
      reset_reset = (i > 0 && $urandom_range(0, 499) == 0);
      step(1);
    end
    reset_reset = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
